spi_bus_arbiter: RTL and testbench
==================================

# spi_bus_arbiter

Sequences and shares the SPI slave link between two on-chip requesters. The block is the SPI master: it owns `cs`, `sclk` and `mosi`, runs one 8-bit full-duplex transfer per grant, and returns the byte shifted in on `miso`. Round-robin arbitration keeps either requester from starving the shared slave. It sits between the user logic and the FPGA pins that drive the slave's `cs`/`sclk`/`sdi`/`sdo`.

## Interface
- `HALF`, 4: `sclk` half-period in `clk` cycles; legal range ≥1.
- `CS_GAP`, 2: minimum `cs`-high cycles between transfers; legal range ≥1.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  2  request per requester; level, held until matching `done`.
- `tx_data0`  in  8  byte to send for requester 0.
- `tx_data1`  in  8  byte to send for requester 1.
- `gnt`  out  2  one-hot owner of the current transfer; 0 when idle.
- `done`  out  2  one-cycle pulse to the owner at transfer end.
- `rx_data`  out  8  last received byte; valid from `done` until the next `done`.
- `busy`  out  1  high from grant through the end of the gap.
- `cs`  out  1  slave select, active low.
- `sclk`  out  1  serial clock, idle low.
- `mosi`  out  1  to slave `sdi`.
- `miso`  in  1  from slave `sdo`.

## Operation
- FSM states: IDLE, SETUP, SHIFT, GAP.
- IDLE: if any `req` bit is set, grant per round-robin. `last` holds the last granted index and resets to 1, so requester 0 wins first. Grant goes to the other index if it is requesting, otherwise to the same index.
- On grant, at one edge: latch the owner's `tx_data` into the shift register, set `gnt`, drive `cs`=0, drive `mosi`=bit 7, and go to SETUP.
- SETUP, HALF cycles: then `sclk`→1 and go to SHIFT.
- SHIFT: 8 bits, MSB first.
  - On each `sclk` rise edge (the clk edge that drives `sclk` high): sample `miso` into bit 0 and shift left.
  - After HALF cycles `sclk`→0, and `mosi` takes the next bit.
  - After the 8th rise and its following low phase (HALF cycles), go to GAP.
- GAP entry, at one edge: `cs`→1, `sclk`=0, `mosi`→0, `rx_data`← shift register, `done[owner]`=1 for one cycle, `gnt`→0, `last`←owner.
- GAP holds for CS_GAP cycles with `cs` high, then returns to IDLE.
- `req` changes after grant are ignored. A transfer always completes, and `tx_data` changes after grant have no effect.
- A requester still holding `req` after `done` is a new request and arbitrates normally in IDLE.
- Bit counter is 3 bits plus a phase flag. Half-period counter is width clog2(HALF) or 1; it wraps to 0 at HALF-1.

## Timing
- Reset values, asynchronous: `cs`=1, `sclk`=0, `mosi`=0, `gnt`=0, `done`=0, `rx_data`=0, `busy`=0, state IDLE, `last`=1.
- Reset mid-transfer aborts immediately to these values. No `done` is issued.
- Grant latency: `req` seen in IDLE at edge N → `gnt`, `busy` and `cs`=0 visible after edge N.
- `cs` low for exactly 17·HALF cycles. The first `sclk` rise comes HALF cycles after `cs` falls. `sclk` high phases last HALF cycles; 8 rises per transfer.
- `done` asserts in the same cycle `cs` returns high.
- Minimum request-to-request period for one requester: 1 + 17·HALF + CS_GAP cycles. With defaults that is 71.
- `busy` drops in the cycle the FSM re-enters IDLE.
- Simultaneous `req`=2'b11 in IDLE: grant goes to the index ≠ `last`.

## Test plan
- Loopback (`miso`=`mosi`), HALF=4: requester 0 sends 8'h3C.
  - `cs` low 68 cycles with 8 `sclk` rises.
  - `mosi` sequence 0,0,1,1,1,1,0,0.
  - `done`=2'b01 and `rx_data`=8'h3C.
- Slave model matching the link protocol (samples `sdi` on `sclk` rise, updates `sdo` on `sclk` fall, loads 8'hA5 while `cs` high): send 8'h96.
  - Slave receives 8'h96.
  - `rx_data` equals the byte the model drives, which the bench checks bit-for-bit.
- Contention: `req`=2'b11 held for 4 transfers after reset → grant order 0,1,0,1; each `done` is a single cycle; gap ≥2 cycles between `cs` pulses.
- Starvation check: `req[0]` held continuously, `req[1]` raised mid-transfer → the next grant goes to 1.
- Reset during bit 4 of a transfer → `cs`=1, `sclk`=0, `gnt`=0 asynchronously, and no `done` pulse. A new `req` after reset is granted to requester 0.
- HALF=1, CS_GAP=1: back-to-back requests from requester 1 with tx 8'hFF then 8'h00 under loopback → `rx_data` is 8'hFF then 8'h00, and the period is 19 cycles.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
//
// SPI master shared by two on-chip requesters. Each grant runs one 8-bit,
// MSB-first, full-duplex transfer on cs/sclk/mosi/miso and returns the byte
// shifted in from the slave. Round-robin arbitration alternates between the
// requesters whenever both are asking, so neither can starve the other.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   req[1:0]  per-requester level request
//   tx_data0  byte sent when requester 0 owns the link
//   tx_data1  byte sent when requester 1 owns the link
//   gnt[1:0]  one-hot owner of the running transfer, 0 when idle
//   done[1:0] one-cycle pulse to the owner when its transfer ends
//   rx_data   byte received by the most recent transfer
//   busy      high from grant until the FSM is back in IDLE
//   cs        slave select, active low
//   sclk      serial clock, idles low
//   mosi      serial data to the slave
//   miso      serial data from the slave
//
// Handshake: req[i] acts as "valid" and stays high until done[i]; gnt[i]
// is the "ready/accept" and marks the point where tx_data_i is captured.
// After gnt the requester may change req and tx_data freely; the transfer
// always runs to completion and done[i] pulses exactly once. A req[i] still
// high after done[i] is treated as a fresh request.

module spi_bus_arbiter #(
    parameter int HALF   = 4,
    parameter int CS_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       cs,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(HALF - 1);
    localparam logic [GW-1:0] G_LAST = GW'(CS_GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic [GW-1:0] gcnt, gcnt_nxt;
    logic [2:0]    bcnt, bcnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          last, last_nxt;
    logic [1:0]    gnt_nxt;
    logic [1:0]    done_nxt;
    logic [7:0]    rx_nxt;
    logic          busy_nxt;
    logic          cs_nxt;
    logic          sclk_nxt;
    logic          mosi_nxt;
    logic          pick;

    // The registered sclk doubles as the bit phase flag: high phase ends in
    // a fall (next mosi bit), low phase ends in a rise (sample) or in GAP
    // once the eighth bit's low phase has elapsed.
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        gcnt_nxt  = gcnt;
        bcnt_nxt  = bcnt;
        shreg_nxt = shreg;
        last_nxt  = last;
        gnt_nxt   = gnt;
        done_nxt  = 2'b00;
        rx_nxt    = rx_data;
        busy_nxt  = busy;
        cs_nxt    = cs;
        sclk_nxt  = sclk;
        mosi_nxt  = mosi;
        // Prefer the requester that did not win last time; fall back to the
        // previous winner when it is the only one asking.
        pick      = req[~last] ? ~last : last;

        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt   = pick ? 2'b10 : 2'b01;
                    shreg_nxt = pick ? tx_data1 : tx_data0;
                    mosi_nxt  = shreg_nxt[7];
                    cs_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    hcnt_nxt  = '0;
                    bcnt_nxt  = 3'd0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (hcnt == H_LAST) begin
                    hcnt_nxt  = '0;
                    sclk_nxt  = 1'b1;
                    shreg_nxt = {shreg[6:0], miso};
                    state_nxt = SHIFT;
                end else begin
                    hcnt_nxt = hcnt + 1'b1;
                end
            end
            SHIFT: begin
                if (hcnt != H_LAST) begin
                    hcnt_nxt = hcnt + 1'b1;
                end else begin
                    hcnt_nxt = '0;
                    if (sclk) begin
                        sclk_nxt = 1'b0;
                        mosi_nxt = shreg[7];
                    end else if (bcnt == 3'd7) begin
                        state_nxt = GAP;
                        cs_nxt    = 1'b1;
                        sclk_nxt  = 1'b0;
                        mosi_nxt  = 1'b0;
                        rx_nxt    = shreg;
                        done_nxt  = gnt;
                        gnt_nxt   = 2'b00;
                        last_nxt  = gnt[1];
                        gcnt_nxt  = '0;
                    end else begin
                        bcnt_nxt  = bcnt + 3'd1;
                        sclk_nxt  = 1'b1;
                        shreg_nxt = {shreg[6:0], miso};
                    end
                end
            end
            GAP: begin
                if (gcnt == G_LAST) begin
                    gcnt_nxt  = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    gcnt_nxt = gcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hcnt    <= '0;
            gcnt    <= '0;
            bcnt    <= 3'd0;
            shreg   <= 8'h00;
            last    <= 1'b1;
            gnt     <= 2'b00;
            done    <= 2'b00;
            rx_data <= 8'h00;
            busy    <= 1'b0;
            cs      <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else begin
            state   <= state_nxt;
            hcnt    <= hcnt_nxt;
            gcnt    <= gcnt_nxt;
            bcnt    <= bcnt_nxt;
            shreg   <= shreg_nxt;
            last    <= last_nxt;
            gnt     <= gnt_nxt;
            done    <= done_nxt;
            rx_data <= rx_nxt;
            busy    <= busy_nxt;
            cs      <= cs_nxt;
            sclk    <= sclk_nxt;
            mosi    <= mosi_nxt;
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter
//
// Drives spi_bus_arbiter with default timing (HALF=4, CS_GAP=2) against a
// loopback or a small SPI slave model, plus a second instance with HALF=1,
// CS_GAP=1 for the back-to-back period case.

module tb_spi_bus_arbiter;

    localparam int HALF   = 4;
    localparam int CS_GAP = 2;
    localparam int LIMIT  = 400;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- default instance ----------------
    logic [1:0] req;
    logic [7:0] tx0, tx1;
    logic [1:0] gnt, done;
    logic [7:0] rx;
    logic       busy, cs, sclk, mosi, miso;
    logic       loopback;

    spi_bus_arbiter #(.HALF(HALF), .CS_GAP(CS_GAP)) u_dut (
        .clk(clk), .rst(rst), .req(req), .tx_data0(tx0), .tx_data1(tx1),
        .gnt(gnt), .done(done), .rx_data(rx), .busy(busy),
        .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    // slave: samples sdi on sclk rise, shifts sdo on sclk fall, reloads while cs high
    logic [7:0] sl_tx = 8'hA5;
    logic [7:0] sl_rx = 8'h00;
    always @(negedge sclk or posedge cs)
        if (cs) sl_tx <= 8'hA5;
        else    sl_tx <= {sl_tx[6:0], 1'b0};
    always @(posedge sclk) sl_rx <= {sl_rx[6:0], mosi};
    assign miso = loopback ? mosi : sl_tx[7];

    // ---------------- fast instance ----------------
    logic [1:0] req_f;
    logic [7:0] tx0_f, tx1_f;
    logic [1:0] gnt_f, done_f;
    logic [7:0] rx_f;
    logic       busy_f, cs_f, sclk_f, mosi_f, miso_f;

    spi_bus_arbiter #(.HALF(1), .CS_GAP(1)) u_dut_fast (
        .clk(clk), .rst(rst), .req(req_f), .tx_data0(tx0_f), .tx_data1(tx1_f),
        .gnt(gnt_f), .done(done_f), .rx_data(rx_f), .busy(busy_f),
        .cs(cs_f), .sclk(sclk_f), .mosi(mosi_f), .miso(miso_f)
    );
    assign miso_f = mosi_f;

    // ---------------- scoreboard ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        n_vec++;
        n_err++;
        $display("FAIL timeout %s: no event within %0d cycles", name, LIMIT);
    endtask

    // ---------------- driver tasks (all called at a negedge) ----------------
    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < LIMIT) begin @(negedge clk); n++; end
        if (busy !== 1'b0) tmo("wait_idle");
    endtask

    task automatic wait_gnt();
        int n = 0;
        while (gnt == 2'b00 && n < LIMIT) begin @(negedge clk); n++; end
        if (gnt == 2'b00) tmo("wait_gnt");
    endtask

    task automatic wait_done();
        int n = 0;
        while (done == 2'b00 && n < LIMIT) begin @(negedge clk); n++; end
        if (done == 2'b00) tmo("wait_done");
    endtask

    // One full transfer from idle: grant latency, cs width, 8 rises, mosi bits,
    // done pulse and rx byte. Optionally scrambles req/tx while in flight.
    task automatic run_xfer(input logic [1:0] r, input logic [7:0] t0, input logic [7:0] t1,
                            input logic [1:0] exp_gnt, input logic [7:0] exp_rx,
                            input bit scramble, output logic [7:0] miso_cap);
        int         lat, cs_cnt, rises;
        logic       prev;
        logic [7:0] mcap, exp_tx;
        exp_tx = exp_gnt[1] ? t1 : t0;
        wait_idle();
        req = r; tx0 = t0; tx1 = t1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (gnt == 2'b00 && lat < LIMIT);
        if (gnt == 2'b00) tmo("xfer_gnt");
        check("gnt_latency", lat, 1);
        check("gnt", gnt, exp_gnt);
        check("cs_at_grant", cs, 1'b0);
        check("busy_at_grant", busy, 1'b1);
        cs_cnt = 0; rises = 0; prev = 1'b0; mcap = 8'h00; miso_cap = 8'h00;
        while (cs == 1'b0 && cs_cnt < LIMIT) begin
            cs_cnt++;
            if (sclk && !prev) begin
                rises++;
                mcap     = {mcap[6:0], mosi};
                miso_cap = {miso_cap[6:0], miso};
            end
            prev = sclk;
            if (scramble) begin
                tx0 = 8'($urandom); tx1 = 8'($urandom); req = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
        end
        if (cs !== 1'b1) tmo("xfer_cs_high");
        check("cs_low_cycles", cs_cnt, 17 * HALF);
        check("sclk_rises", rises, 8);
        check("mosi_bits", mcap, exp_tx);
        check("done", done, exp_gnt);
        check("rx_data", rx, exp_rx);
        check("gnt_after", gnt, 2'b00);
        check("sclk_after", sclk, 1'b0);
        req = 2'b00;
        @(negedge clk);
        check("done_width", done, 2'b00);
    endtask

    // ---------------- vectors ----------------
    typedef struct packed {
        logic [1:0] req;
        logic [7:0] tx0;
        logic [7:0] tx1;
        logic [1:0] exp_gnt;
        logic [7:0] exp_rx;
    } vec_t;
    vec_t vecs[7];

    initial begin
        logic [7:0] mc;
        logic [1:0] r;
        logic [7:0] t0, t1, e;
        bit         own, m_last;
        int         n, rises, gap, tg, tprev;
        logic       prev, seen;

        vecs[0] = '{2'b01, 8'h3C, 8'h00, 2'b01, 8'h3C};
        vecs[1] = '{2'b01, 8'h81, 8'h7E, 2'b01, 8'h81};
        vecs[2] = '{2'b10, 8'h00, 8'h5A, 2'b10, 8'h5A};
        vecs[3] = '{2'b11, 8'hF0, 8'h0F, 2'b01, 8'hF0};
        vecs[4] = '{2'b11, 8'h12, 8'h34, 2'b10, 8'h34};
        vecs[5] = '{2'b10, 8'h99, 8'hC3, 2'b10, 8'hC3};
        vecs[6] = '{2'b11, 8'h00, 8'hFF, 2'b01, 8'h00};

        rst = 1'b1; req = 2'b00; tx0 = 8'h00; tx1 = 8'h00; loopback = 1'b0;
        req_f = 2'b00; tx0_f = 8'h00; tx1_f = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cs", cs, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_gnt", gnt, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_rx", rx, 8'h00);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // slave model: master sends 96, slave returns A5
        run_xfer(2'b01, 8'h96, 8'h00, 2'b01, 8'hA5, 1'b0, mc);
        check("slave_rx", sl_rx, 8'h96);
        for (int b = 0; b < 8; b++) check("rx_bit_vs_miso", rx[b], mc[b]);

        // table-driven loopback transfers
        loopback = 1'b1;
        m_last = 1'b0;
        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i].req, vecs[i].tx0, vecs[i].tx1, vecs[i].exp_gnt, vecs[i].exp_rx, 1'b0, mc);
            m_last = vecs[i].exp_gnt[1];
        end

        // randomized loopback transfers against the round-robin rule
        for (int i = 0; i < 16; i++) begin
            r  = 2'($urandom_range(1, 3));
            t0 = 8'($urandom);
            t1 = 8'($urandom);
            if (r == 2'b11) own = !m_last;
            else            own = r[1];
            exp_q.push_back(own ? t1 : t0);
            e = exp_q.pop_front();
            run_xfer(r, t0, t1, own ? 2'b10 : 2'b01, e, i[0], mc);
            m_last = own;
        end

        // starvation: req[0] held, req[1] arrives mid-transfer
        wait_idle();
        req = 2'b01; tx0 = 8'h6B; tx1 = 8'h55;
        @(negedge clk);
        wait_gnt();
        check("starve_first", gnt, 2'b01);
        repeat (20) @(negedge clk);
        req = 2'b11;
        wait_done();
        check("starve_done0", done, 2'b01);
        check("starve_rx0", rx, 8'h6B);
        @(negedge clk);
        wait_gnt();
        check("starve_next", gnt, 2'b10);
        wait_done();
        check("starve_rx1", rx, 8'h55);
        req = 2'b00;

        // reset during bit 4
        wait_idle();
        req = 2'b01; tx0 = 8'hA7;
        @(negedge clk);
        wait_gnt();
        rises = 0; prev = 1'b0; n = 0;
        while (rises < 5 && n < LIMIT) begin
            if (sclk && !prev) rises++;
            prev = sclk;
            if (rises < 5) begin @(negedge clk); n++; end
        end
        if (rises < 5) tmo("bit4");
        #2 rst = 1'b1; req = 2'b00;
        #1;
        check("abort_cs", cs, 1'b1);
        check("abort_sclk", sclk, 1'b0);
        check("abort_gnt", gnt, 2'b00);
        check("abort_done", done, 2'b00);
        check("abort_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (80) begin @(negedge clk); if (done != 2'b00) seen = 1'b1; end
        check("no_done_after_abort", seen, 1'b0);

        // contention after reset: 0,1,0,1 with fixed period and gap
        req = 2'b11; tx0 = 8'hC1; tx1 = 8'h1C;
        tprev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt();
            tg = cyc;
            check("rr_order", gnt, k[0] ? 2'b10 : 2'b01);
            if (k > 0) check("rr_period", tg - tprev, 1 + 17 * HALF + CS_GAP);
            tprev = tg;
            wait_done();
            check("rr_done", done, k[0] ? 2'b10 : 2'b01);
            check("rr_rx", rx, k[0] ? 8'h1C : 8'hC1);
            if (k == 3) req = 2'b00;
            gap = 0;
            while (cs == 1'b1 && gap < LIMIT && (k < 3 || gap < 2)) begin
                gap++;
                @(negedge clk);
                if (gap == 1) check("rr_done_width", done, 2'b00);
            end
            if (k < 3) check("rr_gap", gap, CS_GAP + 1);
        end

        // HALF=1, CS_GAP=1: requester 1 back to back, FF then 00
        wait_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_f = 2'b10; tx1_f = 8'hFF;
        n = 0;
        while (gnt_f == 2'b00 && n < LIMIT) begin @(negedge clk); n++; end
        if (gnt_f == 2'b00) tmo("fast_gnt0");
        check("fast_gnt0", gnt_f, 2'b10);
        tprev = cyc;
        tx1_f = 8'h00;
        n = 0;
        while (done_f == 2'b00 && n < LIMIT) begin @(negedge clk); n++; end
        if (done_f == 2'b00) tmo("fast_done0");
        check("fast_done0", done_f, 2'b10);
        check("fast_rx0", rx_f, 8'hFF);
        n = 0;
        while (gnt_f == 2'b00 && n < LIMIT) begin @(negedge clk); n++; end
        if (gnt_f == 2'b00) tmo("fast_gnt1");
        check("fast_period", cyc - tprev, 19);
        n = 0;
        while (done_f == 2'b00 && n < LIMIT) begin @(negedge clk); n++; end
        if (done_f == 2'b00) tmo("fast_done1");
        check("fast_rx1", rx_f, 8'h00);
        req_f = 2'b00;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
